mac_dot_sequencer: RTL
======================

Name: mac_dot_sequencer

Overview:
Master-side controller for the team's 4-stage pipelined Q5.10 MAC. It computes one dot product of a runtime length from a streamed (a,b) element pair interface. It drives the MAC's start/a/b/acc_in and consumes its acc_out/valid. The MAC feedback hazard is hidden by interleaving LANES partial sums. When all elements are in, the partials are reduced and the 32-bit result is presented on a valid/ready output.

Parameters:
WIDTH, 16, operand width (Q5.10; 1 sign, 5 int, 10 frac)
LANES, 5, partial-sum lanes; 5 gives one issue per cycle against the 4-cycle MAC round trip
LEN_W, 16, width of the length field

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
go  in  1  start job; sampled only in IDLE
len  in  LEN_W  number of element pairs; sampled with go
busy  out  1  state != IDLE
err  out  1  sticky: mac_valid seen with no lane pending; cleared on accepted go
in_valid  in  1  element pair valid
in_ready  out  1  element pair accepted when in_valid && in_ready
in_a  in  WIDTH  signed operand a
in_b  in  WIDTH  signed operand b
mac_start  out  1  issue to MAC
mac_a  out  WIDTH  MAC operand a
mac_b  out  WIDTH  MAC operand b
mac_acc_in  out  2*WIDTH  MAC accumulator input
mac_acc_out  in  2*WIDTH  MAC result
mac_valid  in  1  MAC result valid
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_data  out  2*WIDTH  signed dot product, Q.10 in 32 bits

Behaviour:
- Reset values: state=IDLE, all outputs 0, lanes 0, pending 0, issue_ptr=ret_ptr=0, counters 0, err=0.
- MAC contract: start in cycle c gives mac_valid in cycle c+4, with acc_out = acc_in + (a*b >>> 10). Results return in issue order.
- States: IDLE, RUN, DRAIN, REDUCE, OUT.
- IDLE, go=1, len>0: clear lanes, pending, pointers, issued count, err. Go to RUN.
- IDLE, go=1, len=0: sum=0. Go to OUT.
- go outside IDLE is ignored.
- RUN: in_ready = !pending[issue_ptr] && issued < len. in_ready must not depend on in_valid.
- RUN fire: mac_start=1 in the same cycle. mac_a=in_a and mac_b=in_b (combinational pass-through). mac_acc_in = lane[issue_ptr].
- RUN fire also sets pending[issue_ptr], advances issue_ptr mod LANES, and increments issued.
- mac_start=0 whenever there is no fire; mac_a, mac_b, mac_acc_in are don't-care then.
- RUN exits to DRAIN in the cycle after issued reaches len.
- Return path, active in any state: when mac_valid=1 and pending[ret_ptr]=1, capture lane[ret_ptr] <= mac_acc_out, clear pending[ret_ptr], advance ret_ptr mod LANES.
- If mac_valid=1 and pending[ret_ptr]=0: set err, discard the data, leave the pointer unchanged.
- Same-cycle return and issue: a lane returning this cycle is still pending, so it cannot be issued until the next cycle. No bypass. Lane period is 5 cycles.
- DRAIN: when pending==0, go to REDUCE with sum=0.
- REDUCE: LANES cycles. Cycle j: sum <= sum + lane[j]. Then go to OUT.
- Arithmetic: 2*WIDTH two's complement, wrap on overflow, no saturation.
- OUT: res_valid=1 and res_data=sum, held stable until res_ready=1. On the handshake, go to IDLE and drop res_valid the next cycle.
- res_data holds its last value in IDLE.
- Latency, LANES=5: with go in cycle g and inputs always valid, the last MAC issue of len=3 is at g+3. res_valid first rises in cycle g+14.
- len=0: res_valid rises in cycle g+1.
- Reset mid-operation: immediate return to reset values. A MAC result arriving after reset release sets err; the MAC must be reset together with this block.

Test Plan:
- Bench drives the team's MAC (WIDTH=16) as the slave.
- len=3, pairs (1536,2048), (-512,4096), (1024,1024), in_valid held high -> mac_start high cycles g+1..g+3, in_ready low after the 3rd fire, res_valid at g+14, res_data=2048 (2.0).
- len=12, all pairs (1024,1024), LANES=5 -> 12 consecutive fires with no in_ready gaps, res_data=12288.
- Same stimulus with LANES=2 -> fires in pairs with 3-cycle gaps, res_data=12288.
- len=0 -> no mac_start, res_valid at g+1, res_data=0.
- len=2, res_ready held low 10 cycles -> res_valid and res_data stable, go pulses ignored, busy=1; IDLE in the cycle after res_ready=1.
- Assert rst during RUN after 2 fires -> all outputs 0 immediately; next job len=1 (2048,2048) -> res_data=4096.
- Inject mac_valid in IDLE -> err=1, lanes unchanged; next accepted go clears err.

Source files
------------

// File: rtl/mac_dot_sequencer_if.sv
// Bundles the job-control, element-stream, MAC and result signals of the dot-product sequencer.
// master is the sequencer's view; slave is the surrounding system (source, MAC, sink).
interface mac_dot_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 16
);
  logic                      go;
  logic [LEN_W-1:0]          len;
  logic                      busy;
  logic                      err;

  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   in_a;
  logic signed [WIDTH-1:0]   in_b;

  logic                      mac_start;
  logic signed [WIDTH-1:0]   mac_a;
  logic signed [WIDTH-1:0]   mac_b;
  logic signed [2*WIDTH-1:0] mac_acc_in;
  logic signed [2*WIDTH-1:0] mac_acc_out;
  logic                      mac_valid;

  logic                      res_valid;
  logic                      res_ready;
  logic signed [2*WIDTH-1:0] res_data;

  modport master (
    input  go, len, in_valid, in_a, in_b, mac_acc_out, mac_valid, res_ready,
    output busy, err, in_ready, mac_start, mac_a, mac_b, mac_acc_in, res_valid, res_data
  );

  modport slave (
    output go, len, in_valid, in_a, in_b, mac_acc_out, mac_valid, res_ready,
    input  busy, err, in_ready, mac_start, mac_a, mac_b, mac_acc_in, res_valid, res_data
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Streams (a,b) pairs into a 4-stage MAC, interleaving LANES partial sums to hide the
// accumulator feedback latency, then reduces the partials into one 2*WIDTH result.
module mac_dot_sequencer #(
  parameter int WIDTH = 16,
  parameter int LANES = 5,
  parameter int LEN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  mac_dot_sequencer_if.master io_bus
);
  localparam int ACC_W = 2 * WIDTH;
  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_REDUCE,
    S_OUT
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [LANES-1:0]         r_pending;
  logic [LANES-1:0]         w_pending_next;
  logic [PTR_W-1:0]         r_issue_ptr;
  logic [PTR_W-1:0]         r_ret_ptr;
  logic [PTR_W-1:0]         r_red_idx;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         r_issued;
  logic signed [ACC_W-1:0]  r_sum;
  logic                     r_err;
  logic signed [ACC_W-1:0]  w_lane [LANES];

  logic w_go_accept;
  logic w_in_ready;
  logic w_fire;
  logic w_ret;
  logic w_stray;
  logic w_drain_done;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_LANE) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_go_accept  = (r_state == S_IDLE) && io_bus.go;
  assign w_fire       = w_in_ready && io_bus.in_valid;
  assign w_ret        = io_bus.mac_valid && r_pending[r_ret_ptr];
  assign w_stray      = io_bus.mac_valid && !r_pending[r_ret_ptr];
  assign w_drain_done = (r_state == S_DRAIN) && (r_pending == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A lane whose result returns this cycle is still pending, so it is not reissued until next cycle.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.go) begin
          w_state_next = (io_bus.len != '0) ? S_RUN : S_OUT;
        end
      end
      S_RUN: begin
        w_in_ready = !r_pending[r_issue_ptr] && (r_issued < r_len);
        if (r_issued == r_len) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_pending == '0) begin
          w_state_next = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (r_red_idx == LAST_LANE) begin
          w_state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (io_bus.res_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pending_next = r_pending;
    if (w_fire) begin
      w_pending_next[r_issue_ptr] = 1'b1;
    end
    if (w_ret) begin
      w_pending_next[r_ret_ptr] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= '0;
      r_issue_ptr <= '0;
      r_ret_ptr   <= '0;
      r_issued    <= '0;
      r_len       <= '0;
      r_err       <= 1'b0;
    end else if (w_go_accept) begin
      r_pending   <= '0;
      r_issue_ptr <= '0;
      r_ret_ptr   <= '0;
      r_issued    <= '0;
      r_len       <= io_bus.len;
      r_err       <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      if (w_fire) begin
        r_issue_ptr <= ptr_inc(r_issue_ptr);
        r_issued    <= r_issued + LEN_W'(1);
      end
      if (w_ret) begin
        r_ret_ptr <= ptr_inc(r_ret_ptr);
      end
      if (w_stray) begin
        r_err <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [ACC_W-1:0] r_lane;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_lane <= '0;
      end else if (w_go_accept) begin
        r_lane <= '0;
      end else if (w_ret && (r_ret_ptr == PTR_W'(gi))) begin
        r_lane <= io_bus.mac_acc_out;
      end
    end

    assign w_lane[gi] = r_lane;
  end

  // r_sum doubles as the result register, so it holds its value through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum     <= '0;
      r_red_idx <= '0;
    end else if (w_go_accept && (io_bus.len == '0)) begin
      r_sum <= '0;
    end else if (w_drain_done) begin
      r_sum     <= '0;
      r_red_idx <= '0;
    end else if (r_state == S_REDUCE) begin
      r_sum     <= r_sum + w_lane[r_red_idx];
      r_red_idx <= ptr_inc(r_red_idx);
    end
  end

  assign io_bus.busy       = (r_state != S_IDLE);
  assign io_bus.err        = r_err;
  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.mac_start  = w_fire;
  assign io_bus.mac_a      = w_fire ? io_bus.in_a : '0;
  assign io_bus.mac_b      = w_fire ? io_bus.in_b : '0;
  assign io_bus.mac_acc_in = w_fire ? w_lane[r_issue_ptr] : '0;
  assign io_bus.res_valid  = (r_state == S_OUT);
  assign io_bus.res_data   = r_sum;
endmodule
